// File: rtl/fetch_unit.sv
// RV32I fetch stage: PC owner, imem request issue, response buffering and redirect flush.
// Optional FETCH_PERF_CNT_EN adds perf_fetched / perf_flushed counters.

module fetch_fifo #(
   parameter int DEPTH = 2,
   parameter int W     = 64
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    flush_i,
   input  logic                    push_i,
   input  logic [W-1:0]            push_dat_i,
   input  logic                    pop_i,
   output logic                    vld_o,
   output logic [W-1:0]            head_dat_o,
   output logic [$clog2(DEPTH):0]  count_o
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_q, rd_q;
   logic [AW:0]   cnt_q;

   always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (push_i) wr_q <= wr_q + AW'(1);
         if (pop_i)  rd_q <= rd_q + AW'(1);
         cnt_q <= cnt_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
      end
   end

   // Storage needs no reset; the count gates visibility.
   always_ff @(posedge clk_i) begin
      if (push_i && !flush_i) mem_q[wr_q] <= push_dat_i;
   end

   assign vld_o      = (cnt_q != '0);
   assign head_dat_o = mem_q[rd_q];
   assign count_o    = cnt_q;
endmodule

module fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        iword_valid,
   input  logic        iword_ready,
   output logic [31:0] iword,
   output logic [31:0] iword_pc
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0] perf_fetched,
   output logic [31:0] perf_flushed
`endif
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic [31:0]   pc_q, pc_d, resp_pc_q, resp_pc_d, redir_pc;
   logic [CW-1:0] outst_q, outst_d, disc_q, disc_d, fifo_cnt;
   logic [CW:0]   inflight;
   logic [63:0]   head_dat;
   logic          req_fire, pop, resp_drop, resp_keep, fifo_vld;
   logic          unused_low_bits;

   assign unused_low_bits = ^redirect_pc[1:0];
   assign redir_pc        = {redirect_pc[31:2], 2'b00};

   // Outstanding plus buffered never exceeds depth, so every response has a slot.
   assign inflight       = {1'b0, outst_q} + {1'b0, fifo_cnt};
   assign imem_req_valid = !rst && (inflight < (CW+1)'(FIFO_DEPTH));
   assign imem_req_addr  = pc_q;

   assign req_fire  = imem_req_valid & imem_req_ready;
   assign pop       = iword_valid & iword_ready;
   assign resp_drop = imem_resp_valid & (redirect_valid | (disc_q != '0));
   assign resp_keep = imem_resp_valid & ~resp_drop;

   always_comb begin
      pc_d      = pc_q;
      resp_pc_d = resp_pc_q;
      disc_d    = disc_q;
      outst_d   = outst_q + CW'(req_fire) - CW'(imem_resp_valid);
      if (redirect_valid) begin
         pc_d      = redir_pc;
         resp_pc_d = redir_pc;
         disc_d    = outst_d;
      end else begin
         if (req_fire)  pc_d      = pc_q + 32'd4;
         if (resp_keep) resp_pc_d = resp_pc_q + 32'd4;
         if (imem_resp_valid && (disc_q != '0)) disc_d = disc_q - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q      <= RESET_PC;
         resp_pc_q <= RESET_PC;
         outst_q   <= '0;
         disc_q    <= '0;
      end else begin
         pc_q      <= pc_d;
         resp_pc_q <= resp_pc_d;
         outst_q   <= outst_d;
         disc_q    <= disc_d;
      end
   end

   fetch_fifo #(.DEPTH(FIFO_DEPTH), .W(64)) u_fifo (
      .clk_i      (clk),
      .rst_i      (rst),
      .flush_i    (redirect_valid),
      .push_i     (resp_keep),
      .push_dat_i ({imem_resp_data, resp_pc_q}),
      .pop_i      (pop),
      .vld_o      (fifo_vld),
      .head_dat_o (head_dat),
      .count_o    (fifo_cnt)
   );

   assign iword_valid = fifo_vld;
   assign iword       = fifo_vld ? head_dat[63:32] : 32'h0;
   assign iword_pc    = fifo_vld ? head_dat[31:0]  : 32'h0;

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_fetched_q, perf_flushed_q, flush_cnt;

   // A word popped in the redirect cycle was delivered, not flushed.
   assign flush_cnt = 32'(resp_drop) +
                      (redirect_valid ? (32'(fifo_cnt) - 32'(pop)) : 32'd0);

   always_ff @(posedge clk) begin
      if (rst) begin
         perf_fetched_q <= '0;
         perf_flushed_q <= '0;
      end else begin
         perf_fetched_q <= perf_fetched_q + 32'(pop);
         perf_flushed_q <= perf_flushed_q + flush_cnt;
      end
   end

   assign perf_fetched = perf_fetched_q;
   assign perf_flushed = perf_flushed_q;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: cycle table plus redirect / reset sequences, with a
// fixed-latency memory model and an in-order scoreboard on delivered words.
module tb_fetch_unit;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b0;
   logic [31:0] imem_req_addr;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        iword_valid;
   logic        iword_ready = 1'b0;
   logic [31:0] iword;
   logic [31:0] iword_pc;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_fetched, perf_flushed;
`endif

   int checks = 0;
   int errors = 0;

   fetch_unit #(.RESET_PC(32'h0), .FIFO_DEPTH(2)) dut (
      .clk             (clk),
      .rst             (rst),
      .imem_req_valid  (imem_req_valid),
      .imem_req_ready  (imem_req_ready),
      .imem_req_addr   (imem_req_addr),
      .imem_resp_valid (imem_resp_valid),
      .imem_resp_data  (imem_resp_data),
      .redirect_valid  (redirect_valid),
      .redirect_pc     (redirect_pc),
      .iword_valid     (iword_valid),
      .iword_ready     (iword_ready),
      .iword           (iword),
      .iword_pc        (iword_pc)
`ifdef FETCH_PERF_CNT_EN
      ,
      .perf_fetched    (perf_fetched),
      .perf_flushed    (perf_flushed)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   // Memory: mem[k] = k, fixed latency lat, response slots shift toward index 0.
   int          lat = 1;
   bit          fire_s = 1'b0, rst_s = 1'b0;
   logic [31:0] addr_s = 32'h0;
   bit          pv [8];
   logic [31:0] pa [8];

   initial begin
      for (int i = 0; i < 8; i++) begin
         pv[i] = 1'b0;
         pa[i] = 32'h0;
      end
   end

   assign imem_resp_valid = pv[0];
   assign imem_resp_data  = pa[0] >> 2;

   always @(posedge clk) begin
      for (int i = 0; i < 7; i++) begin
         pv[i] <= pv[i+1];
         pa[i] <= pa[i+1];
      end
      pv[7] <= 1'b0;
      if (rst_s) begin
         for (int i = 0; i < 8; i++) pv[i] <= 1'b0;
      end else if (fire_s) begin
         pv[lat-1] <= 1'b1;
         pa[lat-1] <= addr_s;
      end
   end

   typedef struct {
      logic [31:0] dat;
      logic [31:0] pc;
   } exp_t;
   exp_t sbq [$];

   // Scoreboard: requests push expectations, redirect/reset drop all of them,
   // a handshake in the redirect cycle still counts as delivered.
   always @(negedge clk) begin
      fire_s <= imem_req_valid && imem_req_ready;
      addr_s <= imem_req_addr;
      rst_s  <= rst;
      if (rst) begin
         sbq.delete();
      end else begin
         if (iword_valid && iword_ready) begin
            if (sbq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL sb_unexpected actual_pc=%h required=no word", iword_pc);
            end else begin
               chk("sb_iword", iword, sbq[0].dat);
               chk("sb_iword_pc", iword_pc, sbq[0].pc);
               void'(sbq.pop_front());
            end
         end
         if (redirect_valid) sbq.delete();
         else if (imem_req_valid && imem_req_ready)
            sbq.push_back('{imem_req_addr >> 2, imem_req_addr});
      end
   end

   task automatic step(input bit r, input bit rr, input bit ir, input bit rd, input logic [31:0] rpc);
      @(posedge clk);
      #1;
      rst            = r;
      imem_req_ready = rr;
      iword_ready    = ir;
      redirect_valid = rd;
      redirect_pc    = rpc;
      @(negedge clk);
   endtask

   task automatic do_reset(input int l);
      step(1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      lat = l;
   endtask

   task automatic wait_iv(input int maxc, input string nm, input logic [31:0] epc);
      bit seen = 1'b0;
      for (int i = 0; i < maxc && !seen; i++) begin
         step(0, 1, 1, 0, 0);
         if (iword_valid) seen = 1'b1;
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL %s timeout actual=no iword_valid required=pc %h", nm, epc);
      end else begin
         chk({nm, "_pc"}, iword_pc, epc);
         chk({nm, "_word"}, iword, epc >> 2);
      end
   endtask

   typedef struct {
      bit          r;
      bit          rr;
      bit          ir;
      bit          erv;
      logic [31:0] eaddr;
      bit          eiv;
      logic [31:0] epc;
   } vec_t;
   localparam int NV = 28;
   vec_t tbl [NV];

   initial begin
      // Depth 2, latency 1: streaming, decoder stall, req stall at 0x20, mid-stream reset.
      tbl[0]  = '{0, 1, 1, 1, 32'h00, 0, 32'h00};
      tbl[1]  = '{0, 1, 1, 1, 32'h04, 0, 32'h00};
      tbl[2]  = '{0, 1, 1, 0, 32'h00, 1, 32'h00};
      tbl[3]  = '{0, 1, 1, 1, 32'h08, 1, 32'h04};
      tbl[4]  = '{0, 1, 1, 1, 32'h0C, 0, 32'h00};
      tbl[5]  = '{0, 1, 1, 0, 32'h00, 1, 32'h08};
      tbl[6]  = '{0, 1, 1, 1, 32'h10, 1, 32'h0C};
      tbl[7]  = '{0, 1, 0, 1, 32'h14, 0, 32'h00};
      tbl[8]  = '{0, 1, 0, 0, 32'h00, 1, 32'h10};
      tbl[9]  = '{0, 1, 0, 0, 32'h00, 1, 32'h10};
      tbl[10] = '{0, 1, 0, 0, 32'h00, 1, 32'h10};
      tbl[11] = '{0, 1, 1, 0, 32'h00, 1, 32'h10};
      tbl[12] = '{0, 1, 0, 1, 32'h18, 1, 32'h14};
      tbl[13] = '{0, 1, 0, 0, 32'h00, 1, 32'h14};
      tbl[14] = '{0, 1, 0, 0, 32'h00, 1, 32'h14};
      tbl[15] = '{0, 1, 0, 0, 32'h00, 1, 32'h14};
      tbl[16] = '{0, 1, 1, 0, 32'h00, 1, 32'h14};
      tbl[17] = '{0, 1, 1, 1, 32'h1C, 1, 32'h18};
      tbl[18] = '{0, 0, 1, 1, 32'h20, 0, 32'h00};
      tbl[19] = '{0, 0, 1, 1, 32'h20, 1, 32'h1C};
      tbl[20] = '{0, 0, 1, 1, 32'h20, 0, 32'h00};
      tbl[21] = '{0, 0, 1, 1, 32'h20, 0, 32'h00};
      tbl[22] = '{0, 0, 1, 1, 32'h20, 0, 32'h00};
      tbl[23] = '{0, 1, 0, 1, 32'h20, 0, 32'h00};
      tbl[24] = '{0, 1, 0, 1, 32'h24, 0, 32'h00};
      tbl[25] = '{1, 1, 0, 0, 32'h00, 1, 32'h20};
      tbl[26] = '{0, 1, 1, 1, 32'h00, 0, 32'h00};
      tbl[27] = '{0, 1, 1, 1, 32'h04, 0, 32'h00};

      do_reset(1);
      chk("rst_req_vld", {31'b0, imem_req_valid}, 32'd0);
      chk("rst_iword_vld", {31'b0, iword_valid}, 32'd0);
      chk("rst_iword", iword, 32'h0);
      chk("rst_iword_pc", iword_pc, 32'h0);

      for (int k = 0; k < NV; k++) begin
         step(tbl[k].r, tbl[k].rr, tbl[k].ir, 0, 32'h0);
         chk($sformatf("c%0d_req_vld", k), {31'b0, imem_req_valid}, {31'b0, tbl[k].erv});
         if (tbl[k].erv) chk($sformatf("c%0d_req_addr", k), imem_req_addr, tbl[k].eaddr);
         chk($sformatf("c%0d_iword_vld", k), {31'b0, iword_valid}, {31'b0, tbl[k].eiv});
         if (tbl[k].eiv) begin
            chk($sformatf("c%0d_iword_pc", k), iword_pc, tbl[k].epc);
            chk($sformatf("c%0d_iword", k), iword, tbl[k].epc >> 2);
         end
      end

      // Redirect to unaligned PC in the same cycle as a handshake of word 0.
      do_reset(1);
      step(0, 1, 1, 0, 32'h0);
      step(0, 1, 1, 0, 32'h0);
      step(0, 1, 1, 1, 32'h103);
      chk("r4_hs_vld", {31'b0, iword_valid}, 32'd1);
      chk("r4_hs_pc", iword_pc, 32'h0);
      step(0, 1, 1, 0, 32'h0);
      chk("r4_iword_vld_after", {31'b0, iword_valid}, 32'd0);
      chk("r4_req_vld_after", {31'b0, imem_req_valid}, 32'd1);
      chk("r4_req_addr_after", imem_req_addr, 32'h100);
      wait_iv(10, "r4_first", 32'h100);

      // Latency 3, redirect with 0x8 and 0xC outstanding.
      do_reset(3);
      for (int i = 0; i < 7; i++) step(0, 1, 1, 0, 32'h0);
      step(0, 1, 1, 1, 32'h100);
      chk("r3_req_vld_redir", {31'b0, imem_req_valid}, 32'd0);
      chk("r3_iword_vld_redir", {31'b0, iword_valid}, 32'd0);
      wait_iv(20, "r3_first", 32'h100);

      // Four words delivered, then redirect with two responses in flight.
      do_reset(3);
      for (int i = 0; i < 12; i++) step(0, 1, 1, 0, 32'h0);
      step(0, 1, 1, 1, 32'h200);
      chk("r6_req_vld_redir", {31'b0, imem_req_valid}, 32'd0);
      chk("r6_iword_vld_redir", {31'b0, iword_valid}, 32'd0);
      for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 32'h0);
`ifdef FETCH_PERF_CNT_EN
      chk("r6_perf_fetched", perf_fetched, 32'd4);
      chk("r6_perf_flushed", perf_flushed, 32'd2);
`endif
      wait_iv(20, "r6_first", 32'h200);

      step(0, 0, 0, 0, 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- RV32I instruction fetch stage; sits directly upstream of the instruction decoder.
- Owns the PC and issues word requests to instruction memory.
- Buffers returned instruction words in a small FIFO and presents them to the decoder with a valid/ready handshake.
- Handles control-flow redirects by flushing buffered words and discarding stale in-flight responses.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
FIFO_DEPTH, 2, instruction buffer entries; power of two, 2..8.

Ports:
clk  in  1  clock.
rst  in  1  synchronous reset, active-high.
imem_req_valid  out  1  fetch request valid.
imem_req_ready  in  1  memory accepts request this cycle.
imem_req_addr  out  32  word address of request, bits[1:0] always 0.
imem_resp_valid  in  1  response valid; in order, fixed latency >=1, cannot be stalled.
imem_resp_data  in  32  returned instruction word.
redirect_valid  in  1  control-flow redirect (branch/jump taken) this cycle.
redirect_pc  in  32  new PC; bits[1:0] ignored (forced 0).
iword_valid  out  1  instruction word available to decoder.
iword_ready  in  1  decoder accepts word.
iword  out  32  instruction word to decoder.
iword_pc  out  32  PC of iword.

Behaviour:
- Clocking and reset: single clock. Reset is synchronous and active-high. Every register updates on the rising edge of clk.
- Reset values: pc=RESET_PC, resp_pc=RESET_PC, FIFO empty, outstanding=0, discard=0. Outputs: imem_req_valid=0, iword_valid=0, iword=0, iword_pc=0.
- Issue rule: imem_req_valid=1 iff not in reset and (outstanding + fifo_count) < FIFO_DEPTH. This guarantees every response has a FIFO slot.
- imem_req_addr = pc register. It is held stable while imem_req_valid=1 and imem_req_ready=0.
- Request accept (valid & ready): pc <= pc+4, wrapping modulo 2^32. outstanding increments.
- Response handling: each imem_resp_valid decrements outstanding.
  - If discard>0, the response is dropped and discard decrements.
  - Otherwise {imem_resp_data, resp_pc} is written to the FIFO and resp_pc <= resp_pc+4.
- FIFO output:
  - iword_valid = FIFO non-empty, driven from registered state only.
  - iword/iword_pc show the head entry. Entries pop on iword_valid & iword_ready.
  - A word written in cycle N is visible at earliest in cycle N+1.
  - Minimum request-accept-to-iword_valid latency = memory latency + 1.
  - Simultaneous push and pop with FIFO full is legal: count is unchanged.
- Redirect (priority over all else):
  - pc <= {redirect_pc[31:2],2'b00}; resp_pc <= the same value.
  - FIFO cleared.
  - discard <= outstanding after this cycle's request/response updates. Includes a request accepted in the redirect cycle; excludes a response arriving in the redirect cycle, which is dropped.
  - A handshake completing in the redirect cycle counts as delivered.
  - Next cycle: iword_valid=0, and imem_req_addr = new PC if the issue rule allows.
- Back-to-back redirects: each recomputes discard; the last one wins.
- Counter widths: outstanding, discard and fifo_count are each clog2(FIFO_DEPTH)+1 bits. Overflow is impossible by the issue rule.
- Reset mid-operation: all state returns to reset values in the same edge. Responses arriving after reset for pre-reset requests are the memory's responsibility; the memory is reset together with this block.

Optional Feature:
FETCH_PERF_CNT_EN
- Defined:
  - Adds output perf_fetched [31:0], counting completed iword handshakes.
  - Adds output perf_flushed [31:0], counting discarded responses plus FIFO entries cleared by redirect.
  - Both reset to 0 and wrap modulo 2^32.
- Undefined: both ports and their logic are absent; behaviour is otherwise identical.

Test Plan:
1. RESET_PC=0, latency 1, imem_req_ready=1, iword_ready=1, mem[k]=k -> requests at 0x0,0x4,0x8,...; iword=0x0/iword_pc=0x0 first valid 2 cycles after first accept; then one word per cycle in order.
2. iword_ready=0, latency 1 -> exactly 2 words buffered, imem_req_valid falls to 0 and stays 0; iword_ready=1 for 1 cycle -> exactly one new request issues.
3. Latency 3 with 2 requests outstanding (0x8, 0xC), redirect_pc=0x100 -> both responses dropped; first iword_pc=0x100, iword=mem[0x40].
4. redirect_pc=0x103 -> next imem_req_addr=0x100; redirect in same cycle as accepted handshake -> that word counted delivered, FIFO empty next cycle.
5. imem_req_ready=0 for 5 cycles at pc=0x20 -> imem_req_addr held 0x20, no pc advance; rst asserted mid-stream -> next cycle imem_req_valid=0, iword_valid=0, then addr restarts at RESET_PC.
6. FETCH_PERF_CNT_EN defined, scenario 3 run after 4 delivered words -> perf_fetched=4, perf_flushed=2.
